// File: rtl/lfsr_msg_decrypt.sv
// rtl/lfsr_msg_decrypt.sv - LFSR message decrypt engine for parity-tagged cipher images
module lfsr_msg_decrypt #(
    parameter logic [7:0]  SRC_BASE = 8'd64,
    parameter logic [7:0]  DST_BASE = 8'd0,
    parameter int unsigned MSG_MAX  = 52,
    parameter int unsigned N_CHECK  = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic [3:0] ptrn_idx,
    output logic [6:0] parity_errs,
    output logic       search_fail
);

    localparam logic [6:0] MSG_MAX_W = 7'(MSG_MAX);
    localparam logic [5:0] N_CHECK_W = 6'(N_CHECK);
    localparam logic [5:0] LAST_BYTE = 6'd63;
    localparam logic [3:0] LAST_PTRN = 4'd8;

    // S_DEC_WR is the write half of a decoded byte: the single memory port
    // cannot read the next cipher byte while the registered write is out.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_SEARCH,
        S_DECODE,
        S_DEC_WR,
        S_FILL,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;       // cipher byte offset being read
    logic [3:0] pidx_q, pidx_d;     // candidate pattern under test
    logic [6:0] seed_q, seed_d;
    logic [6:0] lfsr_q, lfsr_d;     // keystream value for the byte at idx_q
    logic [6:0] k_q, k_d;           // output bytes issued so far
    logic       lead_q, lead_d;     // still inside the zero preamble
    logic [6:0] perr_q, perr_d;
    logic       sfail_q, sfail_d;
    logic [3:0] ptrn_q, ptrn_d;
    logic       ack_q, ack_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic [6:0] rd_low;
    logic       par_bad;
    logic [6:0] plain;

    function automatic logic [6:0] ptrn_of(input logic [3:0] p);
        logic [6:0] t;
        case (p)
            4'd0:    t = 7'h60;
            4'd1:    t = 7'h48;
            4'd2:    t = 7'h78;
            4'd3:    t = 7'h72;
            4'd4:    t = 7'h6A;
            4'd5:    t = 7'h69;
            4'd6:    t = 7'h5C;
            4'd7:    t = 7'h7E;
            default: t = 7'h7B;
        endcase
        return t;
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] taps);
        return {s[5:0], ^(s & taps)};
    endfunction

    assign rd_low      = mem_rd_data[6:0];
    assign par_bad     = mem_rd_data[7] ^ (^mem_rd_data[6:0]);
    assign plain       = rd_low ^ lfsr_q;

    assign Ack         = ack_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;
    assign ptrn_idx    = ptrn_q;
    assign parity_errs = perr_q;
    assign search_fail = sfail_q;

    // State and datapath registers; reset aborts any run in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pidx_q    <= '0;
            seed_q    <= '0;
            lfsr_q    <= '0;
            k_q       <= '0;
            lead_q    <= 1'b0;
            perr_q    <= '0;
            sfail_q   <= 1'b0;
            ptrn_q    <= 4'hF;
            ack_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pidx_q    <= pidx_d;
            seed_q    <= seed_d;
            lfsr_q    <= lfsr_d;
            k_q       <= k_d;
            lead_q    <= lead_d;
            perr_q    <= perr_d;
            sfail_q   <= sfail_d;
            ptrn_q    <= ptrn_d;
            ack_q     <= ack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state, datapath updates and the shared memory address.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pidx_d    = pidx_q;
        seed_d    = seed_q;
        lfsr_d    = lfsr_q;
        k_d       = k_q;
        lead_d    = lead_q;
        perr_d    = perr_q;
        sfail_d   = sfail_q;
        ptrn_d    = ptrn_q;
        ack_d     = ack_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_addr  = 8'h00;

        // A pending write owns the port; otherwise the read address follows idx.
        if (wr_en_q) begin
            mem_addr = wr_addr_q;
        end else begin
            case (state_q)
                S_SEED:             mem_addr = SRC_BASE;
                S_SEARCH, S_DECODE: mem_addr = SRC_BASE + {2'b00, idx_q};
                default:            mem_addr = 8'h00;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (!Start) begin
                    perr_d  = '0;
                    sfail_d = 1'b0;
                    ptrn_d  = 4'hF;
                    state_d = S_SEED;
                end
            end

            // Preamble plaintext is zero, so the first cipher byte is the seed itself.
            S_SEED: begin
                seed_d = rd_low;
                if (rd_low == 7'd0) begin
                    sfail_d = 1'b1;
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    pidx_d  = 4'd0;
                    idx_d   = 6'd1;
                    lfsr_d  = lfsr_step(rd_low, ptrn_of(4'd0));
                    state_d = S_SEARCH;
                end
            end

            S_SEARCH: begin
                if (rd_low == lfsr_q) begin
                    if (idx_q == N_CHECK_W) begin
                        ptrn_d  = pidx_q;
                        idx_d   = 6'd0;
                        lfsr_d  = seed_q;
                        k_d     = 7'd0;
                        lead_d  = 1'b1;
                        state_d = S_DECODE;
                    end else begin
                        idx_d  = idx_q + 6'd1;
                        lfsr_d = lfsr_step(lfsr_q, ptrn_of(pidx_q));
                    end
                end else if (pidx_q == LAST_PTRN) begin
                    sfail_d = 1'b1;
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    pidx_d = pidx_q + 4'd1;
                    idx_d  = 6'd1;
                    lfsr_d = lfsr_step(seed_q, ptrn_of(pidx_q + 4'd1));
                end
            end

            S_DECODE: begin
                if (par_bad && (perr_q != 7'h7F)) begin
                    perr_d = perr_q + 7'd1;
                end
                lfsr_d = lfsr_step(lfsr_q, ptrn_of(ptrn_q));
                if (lead_q && (plain == 7'd0)) begin
                    if (idx_q == LAST_BYTE) begin
                        state_d = S_FILL;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else begin
                    lead_d    = 1'b0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = DST_BASE + {1'b0, k_q};
                    wr_data_d = {1'b0, plain} + 8'h20;
                    k_d       = k_q + 7'd1;
                    state_d   = S_DEC_WR;
                end
            end

            S_DEC_WR: begin
                if (k_q == MSG_MAX_W) begin
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == LAST_BYTE) begin
                    state_d = S_FILL;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_DECODE;
                end
            end

            // One extra cycle after the last issue lets that write retire before DONE.
            S_FILL: begin
                if (k_q < MSG_MAX_W) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = DST_BASE + {1'b0, k_q};
                    wr_data_d = 8'h20;
                    k_d       = k_q + 7'd1;
                end else begin
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (Start) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lfsr_msg_decrypt.sv
// tb/tb_lfsr_msg_decrypt.sv - scoreboard bench for lfsr_msg_decrypt
module tb_lfsr_msg_decrypt;

    localparam int LAT_MAX = 1 + 9 * 8 + 64 + 52 + 2;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [3:0] ptrn_idx;
    logic [6:0] parity_errs;
    logic       search_fail;

    lfsr_msg_decrypt dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Ack         (Ack),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .ptrn_idx    (ptrn_idx),
        .parity_errs (parity_errs),
        .search_fail (search_fail)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [0:255];
    assign mem_rd_data = mem[mem_addr];
    always @(posedge Clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    typedef struct packed {
        logic [3:0] pi;
        logic [6:0] pe;
        logic       sf;
    } res_t;

    wr_t  exp_wr [$];
    res_t exp_res [$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] ptab [0:8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
    logic [7:0] img [0:63];
    logic [6:0] plain_v [0:63];

    string msg_t1 = "Mr. Watson, come here. I want to see you.";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] taps);
        return {s[5:0], ^(s & taps)};
    endfunction

    task automatic set_msg(input string m, input int pre);
        for (int i = 0; i < 64; i++) plain_v[i] = 7'h00;
        for (int i = 0; i < m.len() && pre + i < 64; i++) plain_v[pre + i] = 7'(m[i] - 8'h20);
    endtask

    task automatic encrypt(input logic [6:0] seed, input int p);
        logic [6:0] s;
        logic [6:0] c;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            c      = plain_v[i] ^ s;
            img[i] = {^c, c};
            s      = step(s, ptab[p]);
        end
    endtask

    // Reference: derive every write and the final status from the cipher image alone.
    task automatic model_push();
        logic [6:0] seed;
        logic [6:0] s;
        logic [6:0] pl [0:63];
        int         pf;
        int         f;
        int         k;
        int         last;
        int         perr;
        bit         ok;
        seed = img[0][6:0];
        pf   = -1;
        if (seed != 7'd0) begin
            for (int p = 0; p < 9; p++) begin
                if (pf < 0) begin
                    s  = seed;
                    ok = 1'b1;
                    for (int i = 1; i <= 8; i++) begin
                        s = step(s, ptab[p]);
                        if (img[i][6:0] != s) ok = 1'b0;
                    end
                    if (ok) pf = p;
                end
            end
        end
        if (pf < 0) begin
            exp_res.push_back('{pi: 4'hF, pe: 7'd0, sf: 1'b1});
        end else begin
            s = seed;
            for (int i = 0; i < 64; i++) begin
                pl[i] = img[i][6:0] ^ s;
                s     = step(s, ptab[pf]);
            end
            f = 64;
            for (int i = 63; i >= 0; i--) if (pl[i] != 7'd0) f = i;
            k    = 0;
            last = 63;
            for (int i = f; i < 64 && k < 52; i++) begin
                exp_wr.push_back('{addr: 8'(k), data: {1'b0, pl[i]} + 8'h20});
                k++;
                last = i;
            end
            while (k < 52) begin
                exp_wr.push_back('{addr: 8'(k), data: 8'h20});
                k++;
            end
            perr = 0;
            for (int i = 0; i <= last; i++) if (img[i][7] != ^img[i][6:0]) perr++;
            if (perr > 127) perr = 127;
            exp_res.push_back('{pi: 4'(pf), pe: 7'(perr), sf: 1'b0});
        end
    endtask

    // Monitor: every write and every Ack rising edge is checked against the queues.
    logic ack_prev = 1'b0;
    always @(negedge Clk) begin
        if (Reset) begin
            ack_prev <= 1'b0;
        end else begin
            if (mem_wr_en) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wr_data);
                end else begin
                    check("wr_addr", 32'(mem_addr), 32'(exp_wr[0].addr));
                    check("wr_data", 32'(mem_wr_data), 32'(exp_wr[0].data));
                    void'(exp_wr.pop_front());
                end
            end
            if (Ack && !ack_prev) begin
                if (exp_res.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got Ack 1, expected none");
                end else begin
                    check("ptrn_idx", 32'(ptrn_idx), 32'(exp_res[0].pi));
                    check("parity_errs", 32'(parity_errs), 32'(exp_res[0].pe));
                    check("search_fail", 32'(search_fail), 32'(exp_res[0].sf));
                    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
                    void'(exp_res.pop_front());
                end
            end
            ack_prev <= Ack;
        end
    end

    task automatic check_reset_outputs();
        check("rst_ack", 32'(Ack), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);
        check("rst_ptrn_idx", 32'(ptrn_idx), 32'hF);
        check("rst_parity_errs", 32'(parity_errs), 32'd0);
        check("rst_search_fail", 32'(search_fail), 32'd0);
    endtask

    task automatic load_and_expect();
        for (int i = 0; i < 64; i++) mem[64 + i] <= img[i];
        model_push();
    endtask

    task automatic launch();
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    task automatic wait_ack();
        int cyc;
        cyc = 0;
        while (Ack !== 1'b1 && cyc < 400) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
        check("ack_within_bound", 32'(Ack === 1'b1 && cyc <= LAT_MAX), 32'd1);
    endtask

    task automatic release_start();
        int cyc;
        Start = 1'b1;
        cyc   = 0;
        while (Ack !== 1'b0 && cyc < 10) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
        check("ack_release", 32'(Ack), 32'd0);
    endtask

    task automatic full_run();
        load_and_expect();
        launch();
        wait_ack();
        release_start();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] v;
        logic [6:0] s;
        bit         hit;
        int         pre;
        int         len;
        int         p;

        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        Reset = 1'b1;
        Start = 1'b1;
        repeat (3) @(posedge Clk);
        #1 check_reset_outputs();
        Reset = 1'b0;
        @(posedge Clk);

        // T1
        set_msg(msg_t1, 10);
        encrypt(7'h01, 0);
        full_run();

        // T2
        set_msg(msg_t1, 15);
        encrypt(7'h55, 8);
        full_run();

        // T3
        set_msg(msg_t1, 10);
        encrypt(7'h3C, 7);
        img[20][7] = ~img[20][7];
        img[30][7] = ~img[30][7];
        full_run();

        // T4
        for (int i = 0; i < 64; i++) img[i] = 8'h00;
        full_run();

        // T5: byte 3 matches no pattern's third step
        set_msg(msg_t1, 10);
        encrypt(7'h01, 0);
        v = 7'h00;
        for (int c = 127; c >= 0; c--) begin
            hit = 1'b0;
            for (int q = 0; q < 9; q++) begin
                s = 7'h01;
                for (int j = 0; j < 3; j++) s = step(s, ptab[q]);
                if (s == 7'(c)) hit = 1'b1;
            end
            if (!hit) v = 7'(c);
        end
        img[3] = {^v, v};
        full_run();

        // All-space message
        set_msg("", 10);
        encrypt(7'h2B, 3);
        full_run();

        // T6: reset mid-run, then a clean rerun of T1
        set_msg(msg_t1, 10);
        encrypt(7'h01, 0);
        load_and_expect();
        launch();
        repeat (80) @(posedge Clk);
        #1 Reset = 1'b1;
        Start = 1'b1;
        #2 check_reset_outputs();
        exp_wr.delete();
        exp_res.delete();
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        full_run();

        // T7: Start held low after Ack must not relaunch
        load_and_expect();
        launch();
        wait_ack();
        repeat (20) @(posedge Clk);
        #1 check("ack_held", 32'(Ack), 32'd1);
        release_start();
        full_run();

        // Randomized images
        for (int r = 0; r < 8; r++) begin
            p   = $urandom_range(0, 8);
            pre = $urandom_range(10, 20);
            len = $urandom_range(1, 64 - pre);
            set_msg("", 0);
            for (int i = 0; i < len; i++) plain_v[pre + i] = 7'($urandom_range(0, 127));
            if (plain_v[pre] == 7'd0) plain_v[pre] = 7'd1;
            encrypt(7'($urandom_range(1, 127)), p);
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 7) == 0) img[i][7] = ~img[i][7];
            end
            full_run();
        end

        repeat (3) @(posedge Clk);
        #1 check("scoreboard_drained", 32'(exp_wr.size() + exp_res.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
